mem_lane_aligner: RTL and testbench
===================================

# mem_lane_aligner

Parametrised byte-lane aligner between the RV32I load/store unit and a wide (LINE_BYTES) data memory port. Accepts one scalar load/store per handshake, derives per-lane byte enables from funct3 width and address offset, shifts store data into lanes, and extracts and sign/zero-extends load data. Accesses that cross a line boundary are split into two sequential bus beats. This block replaces the fixed 16-lane combinational byte-enable generator.

## Interface
- LINE_BYTES, 16: bus line width in bytes; power of two, ≥4
- ADDR_W, 32: byte address width
- XLEN, 32: scalar data width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid / req_ready  in / out  1  request handshake
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width: [1:0] 00 byte, 01 half, 10 word; [2] = unsigned (loads only)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  XLEN  store data, LSB-aligned
- bus_valid / bus_ready  out / in  1  beat handshake
- bus_we  out  1  beat is a write
- bus_line_addr  out  ADDR_W  line-aligned address (low log2(LINE_BYTES) bits zero)
- bus_byte_en  out  LINE_BYTES  lane enables
- bus_wdata  out  8*LINE_BYTES  lane-shifted store data
- bus_rvalid  in  1  read data valid for the last accepted read beat
- bus_rdata  in  8*LINE_BYTES  read line
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  qualifies resp_valid: illegal funct3 or unsupported split
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors

## Operation
- States: IDLE, BEAT0, WAIT0, BEAT1, WAIT1, RESP.
- IDLE: req_ready=1; on req_valid capture request. Illegal funct3 (x11, 11x, or store with [2]=1) → RESP with resp_err=1, no bus beat. Otherwise → BEAT0.
- off = addr mod LINE_BYTES; n = 1/2/4; mask = ((1<<n)-1) << off, width LINE_BYTES+3. Beat0 uses mask[LINE_BYTES-1:0] at line(addr); beat1 uses mask overflow bits at line(addr)+LINE_BYTES, modulo 2^ADDR_W (top-of-memory wraps to 0).
- Split needed iff off+n > LINE_BYTES.
- BEATx: bus_valid=1 held, payload stable until bus_ready. On handshake: store → BEAT1 if split and in BEAT0, else RESP; load → WAITx.
- WAITx: on bus_rvalid, latch the enabled lanes of bus_rdata; → BEAT1 if split and in WAIT0, else RESP.
- Load merge: beat0 bytes form the low part, beat1 bytes the high part; funct3[2]=0 sign-extends from bit 8n-1, =1 zero-extends.
- RESP: resp_valid=1 for exactly one cycle, → IDLE. Exactly one outstanding request.
- Reset (any state, including mid-split): state IDLE, all outputs 0 except req_ready=0 while rst_n low; in-flight access is dropped, no response.

## Timing
- Reset values: req_ready 0 (asserted 1 the first cycle after deassertion), bus_valid 0, bus_we 0, bus_line_addr 0, bus_byte_en 0, bus_wdata 0, resp_valid 0, resp_err 0, resp_rdata 0.
- All bus_* and resp_* outputs registered.
- Store, no split, bus_ready tied 1: accept at cycle 0, bus_valid cycle 1, resp_valid cycle 2.
- Load, no split: resp_valid one cycle after bus_rvalid.
- Split adds one beat (plus its rvalid wait for loads); beat1 bus_valid is the cycle after beat0 completes.
- bus_rvalid outside WAITx is ignored.

## Configuration
- MEM_LANE_SPLIT_EN defined: line-crossing accesses split into two beats as above.
- Undefined: line-crossing access responds resp_err=1 in RESP with no bus beat; BEAT1/WAIT1 logic not compiled.

## Structure
- mem_lane_pkg: funct3 width encoding constants, state enum, function for n from funct3.
- Sub-module mem_lane_extract: combinational lane extraction, two-beat merge and sign/zero extension.

## Test plan
- Store byte 0xAB at addr 0x105, LINE_BYTES=16 → one beat, line_addr 0x100, byte_en 0x0020, wdata lane 5 = 0xAB, resp_err 0.
- Load half at 0x20E, rdata lanes 14..15 = 0x80,0xFF, funct3 001 → resp_rdata 0xFFFFFF80; funct3 101 → 0x0000FF80.
- Store word 0x11223344 at 0x10E with split enabled → beat0 line 0x100 en 0xC000, beat1 line 0x110 en 0x0003; resp after second handshake.
- Same access with MEM_LANE_SPLIT_EN undefined → no bus_valid, resp_err 1.
- Store with funct3 100 → resp_err 1, no bus beat, resp_rdata 0.
- rst_n low during WAIT1, bus_ready stalled → outputs zero immediately, no resp_valid, next request handled normally.

Source files
------------

// File: rtl/mem_lane_pkg.sv
// Shared definitions for the byte-lane aligner: funct3 width codes, FSM states and width helpers.
package mem_lane_pkg;

    localparam logic [1:0] F3_BYTE = 2'b00;
    localparam logic [1:0] F3_HALF = 2'b01;
    localparam logic [1:0] F3_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BEAT0,
        ST_WAIT0,
        ST_BEAT1,
        ST_WAIT1,
        ST_RESP
    } state_t;

    function automatic logic [2:0] f3_bytes(input logic [1:0] w);
        case (w)
            F3_BYTE: return 3'd1;
            F3_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Unsigned word does not exist in RV32I and stores have no signedness.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
        return (f3[1:0] == 2'b11) || (f3[2:1] == 2'b11) || (we && f3[2]);
    endfunction

endpackage

// File: rtl/mem_lane_extract.sv
// Combinational load-lane extraction: merges this beat's lanes into the partial word and extends it.
module mem_lane_extract
    import mem_lane_pkg::*;
#(
    parameter int LINE_BYTES = 16,
    parameter int XLEN       = 32,
    parameter int OFF_W      = $clog2(LINE_BYTES)
) (
    input  logic [8*LINE_BYTES-1:0] i_rdata,
    input  logic [OFF_W-1:0]        i_off,
    input  logic [2:0]              i_funct3,
    input  logic                    i_beat1,
    input  logic [XLEN-1:0]         i_acc,
    output logic [XLEN-1:0]         o_merged,
    output logic [XLEN-1:0]         o_ext
);

    localparam int NB = XLEN / 8;

    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v, input logic [1:0] w,
                                               input logic uns);
        logic [XLEN-1:0] r;
        r = v;
        case (w)
            F3_BYTE: r = {{(XLEN-8){~uns & v[7]}}, v[7:0]};
            F3_HALF: r = {{(XLEN-16){~uns & v[15]}}, v[15:0]};
            default: r = v;
        endcase
        return r;
    endfunction

    // Access byte k sits at lane off+k; lanes past the line end arrive in the second beat.
    always_comb begin
        o_merged = i_acc;
        for (int k = 0; k < NB; k++) begin
            if (k < int'(f3_bytes(i_funct3[1:0]))) begin
                if (!i_beat1 && (int'(i_off) + k < LINE_BYTES))
                    o_merged[8*k +: 8] = 8'(i_rdata >> (8 * (int'(i_off) + k)));
                else if (i_beat1 && (int'(i_off) + k >= LINE_BYTES))
                    o_merged[8*k +: 8] = 8'(i_rdata >> (8 * (int'(i_off) + k - LINE_BYTES)));
            end
        end
        o_ext = extend(o_merged, i_funct3[1:0], i_funct3[2]);
    end

endmodule

// File: rtl/mem_lane_aligner.sv
// Scalar load/store to wide-line byte-lane aligner. Define MEM_LANE_SPLIT_EN to split
// line-crossing accesses into two beats; otherwise such accesses complete with an error.
module mem_lane_aligner
    import mem_lane_pkg::*;
#(
    parameter int LINE_BYTES = 16,
    parameter int ADDR_W     = 32,
    parameter int XLEN       = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_we,
    input  logic [2:0]              i_req_funct3,
    input  logic [ADDR_W-1:0]       i_req_addr,
    input  logic [XLEN-1:0]         i_req_wdata,
    output logic                    o_bus_valid,
    input  logic                    i_bus_ready,
    output logic                    o_bus_we,
    output logic [ADDR_W-1:0]       o_bus_line_addr,
    output logic [LINE_BYTES-1:0]   o_bus_byte_en,
    output logic [8*LINE_BYTES-1:0] o_bus_wdata,
    input  logic                    i_bus_rvalid,
    input  logic [8*LINE_BYTES-1:0] i_bus_rdata,
    output logic                    o_resp_valid,
    output logic                    o_resp_err,
    output logic [XLEN-1:0]         o_resp_rdata
);

    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int DW    = 8 * LINE_BYTES;
`ifdef MEM_LANE_SPLIT_EN
    localparam int MW = LINE_BYTES + 3;
    localparam int WW = DW + XLEN;
`else
    localparam int MW = LINE_BYTES;
    localparam int WW = DW;
`endif

    state_t                  r_state;
    logic                    r_we;
    logic [2:0]              r_f3;
    logic [OFF_W-1:0]        r_off;
    logic [XLEN-1:0]         r_acc;
    logic                    r_req_ready;
    logic                    r_bus_valid;
    logic                    r_bus_we;
    logic [ADDR_W-1:0]       r_bus_line_addr;
    logic [LINE_BYTES-1:0]   r_bus_byte_en;
    logic [DW-1:0]           r_bus_wdata;
    logic                    r_resp_valid;
    logic                    r_resp_err;
    logic [XLEN-1:0]         r_resp_rdata;
`ifdef MEM_LANE_SPLIT_EN
    logic                    r_split;
    logic [ADDR_W-1:0]       r_line1;
    logic [LINE_BYTES-1:0]   r_en1;
    logic [DW-1:0]           r_wd1;
    logic [ADDR_W-1:0]       w_line1;
`endif

    logic [OFF_W-1:0]  w_off;
    logic [2:0]        w_n;
    logic [MW-1:0]     w_base;
    logic [MW-1:0]     w_mask;
    logic [XLEN-1:0]   w_wmask;
    logic [WW-1:0]     w_wide;
    logic [ADDR_W-1:0] w_line0;
    logic [OFF_W:0]    w_end;
    logic              w_cross;
    logic              w_illegal;
    logic [XLEN-1:0]   w_merged;
    logic [XLEN-1:0]   w_ext;

    assign w_off     = i_req_addr[OFF_W-1:0];
    assign w_n       = f3_bytes(i_req_funct3[1:0]);
    assign w_base    = (w_n == 3'd1) ? MW'(1) : (w_n == 3'd2) ? MW'(3) : MW'(15);
    assign w_mask    = w_base << w_off;
    assign w_wmask   = (w_n == 3'd1) ? XLEN'(8'hFF) : (w_n == 3'd2) ? XLEN'(16'hFFFF) : '1;
    assign w_wide    = WW'(i_req_wdata & w_wmask) << {w_off, 3'b000};
    assign w_line0   = {i_req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign w_end     = {1'b0, w_off} + (OFF_W+1)'(w_n);
    assign w_cross   = w_end > (OFF_W+1)'(LINE_BYTES);
    assign w_illegal = f3_illegal(i_req_funct3, i_req_we);
`ifdef MEM_LANE_SPLIT_EN
    // Line address arithmetic wraps modulo 2^ADDR_W at the top of memory.
    assign w_line1   = w_line0 + ADDR_W'(LINE_BYTES);
`endif

    mem_lane_extract #(
        .LINE_BYTES (LINE_BYTES),
        .XLEN       (XLEN),
        .OFF_W      (OFF_W)
    ) u_extract (
        .i_rdata  (i_bus_rdata),
        .i_off    (r_off),
        .i_funct3 (r_f3),
        .i_beat1  (r_state == ST_WAIT1),
        .i_acc    (r_acc),
        .o_merged (w_merged),
        .o_ext    (w_ext)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= ST_IDLE;
            r_we            <= 1'b0;
            r_f3            <= '0;
            r_off           <= '0;
            r_acc           <= '0;
            r_req_ready     <= 1'b0;
            r_bus_valid     <= 1'b0;
            r_bus_we        <= 1'b0;
            r_bus_line_addr <= '0;
            r_bus_byte_en   <= '0;
            r_bus_wdata     <= '0;
            r_resp_valid    <= 1'b0;
            r_resp_err      <= 1'b0;
            r_resp_rdata    <= '0;
`ifdef MEM_LANE_SPLIT_EN
            r_split         <= 1'b0;
            r_line1         <= '0;
            r_en1           <= '0;
            r_wd1           <= '0;
`endif
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (r_req_ready && i_req_valid) begin
                        r_req_ready <= 1'b0;
                        r_we        <= i_req_we;
                        r_f3        <= i_req_funct3;
                        r_off       <= w_off;
                        r_acc       <= '0;
`ifdef MEM_LANE_SPLIT_EN
                        r_split     <= w_cross;
                        r_line1     <= w_line1;
                        r_en1       <= {{(LINE_BYTES-3){1'b0}}, w_mask[MW-1:LINE_BYTES]};
                        r_wd1       <= i_req_we ? DW'(w_wide[WW-1:DW]) : '0;
                        if (w_illegal) begin
`else
                        if (w_illegal || w_cross) begin
`endif
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                            r_state      <= ST_RESP;
                        end else begin
                            r_bus_valid     <= 1'b1;
                            r_bus_we        <= i_req_we;
                            r_bus_line_addr <= w_line0;
                            r_bus_byte_en   <= w_mask[LINE_BYTES-1:0];
                            r_bus_wdata     <= i_req_we ? w_wide[DW-1:0] : '0;
                            r_state         <= ST_BEAT0;
                        end
                    end
                end
                ST_BEAT0, ST_BEAT1: begin
                    if (i_bus_ready) begin
`ifdef MEM_LANE_SPLIT_EN
                        // A split store streams its second beat back-to-back.
                        if (r_we && r_split && (r_state == ST_BEAT0)) begin
                            r_bus_line_addr <= r_line1;
                            r_bus_byte_en   <= r_en1;
                            r_bus_wdata     <= r_wd1;
                            r_state         <= ST_BEAT1;
                        end else
`endif
                        begin
                            r_bus_valid     <= 1'b0;
                            r_bus_we        <= 1'b0;
                            r_bus_line_addr <= '0;
                            r_bus_byte_en   <= '0;
                            r_bus_wdata     <= '0;
                            if (r_we) begin
                                r_resp_valid <= 1'b1;
                                r_resp_err   <= 1'b0;
                                r_resp_rdata <= '0;
                                r_state      <= ST_RESP;
                            end
`ifdef MEM_LANE_SPLIT_EN
                            else if (r_state == ST_BEAT1)
                                r_state <= ST_WAIT1;
`endif
                            else
                                r_state <= ST_WAIT0;
                        end
                    end
                end
                ST_WAIT0, ST_WAIT1: begin
                    if (i_bus_rvalid) begin
                        r_acc <= w_merged;
`ifdef MEM_LANE_SPLIT_EN
                        if (r_split && (r_state == ST_WAIT0)) begin
                            r_bus_valid     <= 1'b1;
                            r_bus_we        <= 1'b0;
                            r_bus_line_addr <= r_line1;
                            r_bus_byte_en   <= r_en1;
                            r_bus_wdata     <= '0;
                            r_state         <= ST_BEAT1;
                        end else
`endif
                        begin
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b0;
                            r_resp_rdata <= w_ext;
                            r_state      <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= '0;
                    r_req_ready  <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_req_ready     = r_req_ready;
    assign o_bus_valid     = r_bus_valid;
    assign o_bus_we        = r_bus_we;
    assign o_bus_line_addr = r_bus_line_addr;
    assign o_bus_byte_en   = r_bus_byte_en;
    assign o_bus_wdata     = r_bus_wdata;
    assign o_resp_valid    = r_resp_valid;
    assign o_resp_err      = r_resp_err;
    assign o_resp_rdata    = r_resp_rdata;

endmodule

// File: tb/tb_mem_lane_aligner.sv
// Self-checking bench for mem_lane_aligner (LINE_BYTES=16); split expectations follow MEM_LANE_SPLIT_EN.
module tb_mem_lane_aligner;

    localparam int LB = 16;
    localparam int AW = 32;
    localparam int XL = 32;
    localparam int DW = 8 * LB;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid, req_ready, req_we;
    logic [2:0]      req_funct3;
    logic [AW-1:0]   req_addr;
    logic [XL-1:0]   req_wdata;
    logic            bus_valid, bus_ready, bus_we;
    logic [AW-1:0]   bus_line_addr;
    logic [LB-1:0]   bus_byte_en;
    logic [DW-1:0]   bus_wdata;
    logic            bus_rvalid;
    logic [DW-1:0]   bus_rdata;
    logic            resp_valid, resp_err;
    logic [XL-1:0]   resp_rdata;

    always #5 clk = ~clk;

    mem_lane_aligner #(.LINE_BYTES(LB), .ADDR_W(AW), .XLEN(XL)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_req_valid     (req_valid),
        .o_req_ready     (req_ready),
        .i_req_we        (req_we),
        .i_req_funct3    (req_funct3),
        .i_req_addr      (req_addr),
        .i_req_wdata     (req_wdata),
        .o_bus_valid     (bus_valid),
        .i_bus_ready     (bus_ready),
        .o_bus_we        (bus_we),
        .o_bus_line_addr (bus_line_addr),
        .o_bus_byte_en   (bus_byte_en),
        .o_bus_wdata     (bus_wdata),
        .i_bus_rvalid    (bus_rvalid),
        .i_bus_rdata     (bus_rdata),
        .o_resp_valid    (resp_valid),
        .o_resp_err      (resp_err),
        .o_resp_rdata    (resp_rdata)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          nb;
        logic [31:0] line0, line1;
        logic [15:0] en0, en1;
        logic [127:0] wd0, wd1;
        logic [127:0] rl0, rl1;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t tbl[$];

    localparam logic [127:0] RL_A = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] RL_B = 128'h8F8E8D8C_8B8A8988_87868584_83828180;
    localparam logic [127:0] RL_H = 128'hFF80_0102030405060708090A0B0C0D0E;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input int nb,
                                input logic [31:0] line0, input logic [15:0] en0, input logic [127:0] wd0,
                                input logic [31:0] line1, input logic [15:0] en1, input logic [127:0] wd1,
                                input logic [127:0] rl0, input logic [127:0] rl1,
                                input logic err, input logic [31:0] rdata);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.nb = nb;
        v.line0 = line0; v.en0 = en0; v.wd0 = wd0;
        v.line1 = line1; v.en1 = en1; v.wd1 = wd1;
        v.rl0 = rl0; v.rl1 = rl1; v.err = err; v.rdata = rdata;
        return v;
    endfunction

    task automatic pop_resp(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            chk({nm, "_unexpected"}, resp_valid, 1'b0);
        end else begin
            e = sb.pop_front();
            chk({nm, "_err"}, resp_err, e.err);
            chk({nm, "_rdata"}, resp_rdata, e.rdata);
        end
    endtask

    task automatic drive_req(input vec_t v);
        exp_t e;
        int   t;
        t = 0;
        while (!req_ready && t < 20) begin @(negedge clk); t++; end
        chk("req_ready", req_ready, 1'b1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        e.err = v.err;
        e.rdata = v.rdata;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = 32'hDEADBEEF;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int    t;
        string nm;
        drive_req(v);
        for (int b = 0; b < v.nb; b++) begin
            nm = $sformatf("v%0d_b%0d", idx, b);
            t = 0;
            while (!bus_valid && t < 20) begin @(negedge clk); t++; end
            chk({nm, "_lat"}, t, 0);
            chk({nm, "_we"}, bus_we, v.we);
            chk({nm, "_line"}, bus_line_addr, (b == 0) ? v.line0 : v.line1);
            chk({nm, "_en"}, bus_byte_en, (b == 0) ? v.en0 : v.en1);
            chk({nm, "_wdata"}, bus_wdata, (b == 0) ? v.wd0 : v.wd1);
            @(negedge clk);
            if (!v.we) begin
                chk({nm, "_drop"}, bus_valid, 1'b0);
                bus_rvalid = 1'b1;
                bus_rdata  = (b == 0) ? v.rl0 : v.rl1;
                @(negedge clk);
                bus_rvalid = 1'b0;
                bus_rdata  = '1;
            end
        end
        nm = $sformatf("v%0d", idx);
        if (v.nb == 0) chk({nm, "_nobeat"}, bus_valid, 1'b0);
        t = 0;
        while (!resp_valid && t < 20) begin @(negedge clk); t++; end
        chk({nm, "_resp_lat"}, t, 0);
        pop_resp(nm);
        @(negedge clk);
        chk({nm, "_pulse"}, resp_valid, 1'b0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ready"}, req_ready, 1'b0);
        chk({nm, "_bus"}, {bus_valid, bus_we, bus_line_addr, bus_byte_en}, '0);
        chk({nm, "_wdata"}, bus_wdata, '0);
        chk({nm, "_resp"}, {resp_valid, resp_err, resp_rdata}, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        vec_t v;
        int   t;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0;
        req_wdata = '0; bus_ready = 1'b1; bus_rvalid = 1'b0; bus_rdata = '0;

        // we, f3, addr, wdata, nbeats, line0, en0, wd0, line1, en1, wd1, rline0, rline1, err, rdata
        tbl.push_back(mk(1, 3'b000, 32'h105, 32'h000000AB, 1, 32'h100, 16'h0020, 128'hAB << 40, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 3'b001, 32'h20E, 0, 1, 32'h200, 16'hC000, 0, 0, 0, 0, RL_H, 0, 0, 32'hFFFFFF80));
        tbl.push_back(mk(0, 3'b101, 32'h20E, 0, 1, 32'h200, 16'hC000, 0, 0, 0, 0, RL_H, 0, 0, 32'h0000FF80));
        tbl.push_back(mk(0, 3'b000, 32'h1003, 0, 1, 32'h1000, 16'h0008, 0, 0, 0, 0, RL_B, 0, 0, 32'hFFFFFF83));
        tbl.push_back(mk(0, 3'b100, 32'h1003, 0, 1, 32'h1000, 16'h0008, 0, 0, 0, 0, RL_B, 0, 0, 32'h00000083));
        tbl.push_back(mk(0, 3'b010, 32'h1004, 0, 1, 32'h1000, 16'h00F0, 0, 0, 0, 0, RL_B, 0, 0, 32'h87868584));
        tbl.push_back(mk(0, 3'b101, 32'h100C, 0, 1, 32'h1000, 16'h3000, 0, 0, 0, 0, RL_B, 0, 0, 32'h00008D8C));
        tbl.push_back(mk(0, 3'b010, 32'h50C, 0, 1, 32'h500, 16'hF000, 0, 0, 0, 0, RL_B, 0, 0, 32'h8F8E8D8C));
        tbl.push_back(mk(1, 3'b001, 32'h30A, 32'h1234BEEF, 1, 32'h300, 16'h0C00, 128'hBEEF << 80, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3'b010, 32'h40C, 32'hCAFEF00D, 1, 32'h400, 16'hF000, 128'hCAFEF00D << 96, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3'b100, 32'h500, 32'h12345678, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 3'b011, 32'h600, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 3'b110, 32'h604, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 3'b111, 32'h608, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
`ifdef MEM_LANE_SPLIT_EN
        tbl.push_back(mk(1, 3'b010, 32'h10E, 32'h11223344, 2, 32'h100, 16'hC000, 128'h3344 << 112,
                         32'h110, 16'h0003, 128'h1122, 0, 0, 0, 0));
        tbl.push_back(mk(0, 3'b010, 32'hFFD, 0, 2, 32'hFF0, 16'hE000, 0, 32'h1000, 16'h0001, 0,
                         RL_B, RL_A, 0, 32'h008F8E8D));
        tbl.push_back(mk(0, 3'b001, 32'h1FFF, 0, 2, 32'h1FF0, 16'h8000, 0, 32'h2000, 16'h0001, 0,
                         RL_B, RL_B, 0, 32'hFFFF808F));
        tbl.push_back(mk(1, 3'b001, 32'hFFFFFFFF, 32'h0000A5C3, 2, 32'hFFFFFFF0, 16'h8000, 128'hC3 << 120,
                         32'h0, 16'h0001, 128'hA5, 0, 0, 0, 0));
`else
        tbl.push_back(mk(1, 3'b010, 32'h10E, 32'h11223344, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 3'b010, 32'hFFD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 3'b001, 32'h1FFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 3'b001, 32'hFFFFFFFF, 32'h0000A5C3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
`endif

        // Reset state and first ready cycle
        repeat (2) @(negedge clk);
        chk_all_zero("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_after", req_ready, 1'b1);

        foreach (tbl[i]) run_vec(i, tbl[i]);

        // rvalid while idle must not produce a response
        bus_rvalid = 1'b1; bus_rdata = RL_A;
        repeat (2) @(negedge clk);
        bus_rvalid = 1'b0;
        chk("stray_rvalid_resp", resp_valid, 1'b0);
        chk("stray_rvalid_bus", bus_valid, 1'b0);

        // bus_ready stall: payload held until the handshake
        bus_ready = 1'b0;
        v = mk(1, 3'b000, 32'h600, 32'h0000005A, 1, 32'h600, 16'h0001, 128'h5A, 0, 0, 0, 0, 0, 0, 0);
        drive_req(v);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("stall%0d_valid", c), bus_valid, 1'b1);
            chk($sformatf("stall%0d_line", c), bus_line_addr, 32'h600);
            chk($sformatf("stall%0d_en", c), bus_byte_en, 16'h0001);
            chk($sformatf("stall%0d_noresp", c), resp_valid, 1'b0);
            @(negedge clk);
        end
        bus_ready = 1'b1;
        @(negedge clk);
        chk("stall_resp", resp_valid, 1'b1);
        pop_resp("stall");
        @(negedge clk);

        // Reset while waiting on read data with bus_ready stalled: access dropped
`ifdef MEM_LANE_SPLIT_EN
        v = mk(0, 3'b010, 32'hFFD, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`else
        v = mk(0, 3'b010, 32'h700, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif
        drive_req(v);
        void'(sb.pop_back());
        chk("rstmid_beat0", bus_valid, 1'b1);
        @(negedge clk);
`ifdef MEM_LANE_SPLIT_EN
        bus_rvalid = 1'b1; bus_rdata = RL_A;
        @(negedge clk);
        bus_rvalid = 1'b0;
        chk("rstmid_beat1", bus_valid, 1'b1);
        @(negedge clk);
`endif
        bus_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rstmid");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rstmid%0d_noresp", c), resp_valid, 1'b0);
        end
        rst_n = 1'b1;
        bus_ready = 1'b1;
        @(negedge clk);
        chk("rstmid_ready", req_ready, 1'b1);
        run_vec(100, tbl[0]);
        run_vec(101, tbl[1]);

        t = sb.size();
        chk("sb_empty", t, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
